slink_clk_switch_ctrl: RTL

SLINK_CLK_SWITCH_CTRL -- requirements
Module: slink_clk_switch_ctrl

---
 rtl/slink_clk_switch_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/slink_clk_switch_ctrl.sv
// Link clock-source switch sequencer: selects refclk or phy_clk under a held main_reset,
// with timed select/settle/drain phases and forced fallback to refclk when the PHY clock is lost.
module slink_clk_switch_ctrl #(
  parameter int unsigned SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                phy_clk_req,
  input  logic                phy_clk_ready,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                main_reset,
  output logic                use_phy_clk,
  output logic                link_ready,
  output logic                switch_busy,
  output logic                switch_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEL    = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t              state;
  logic [SETTLE_W-1:0] cnt;
  logic [SETTLE_W-1:0] n_eff;
  logic                fallback;
  logic                tgt;
  logic                lost_phy;
  logic                cnt_last;
  logic                fault;

  assign tgt      = phy_clk_req & phy_clk_ready;
  assign n_eff    = (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
  assign lost_phy = use_phy_clk & ~phy_clk_ready;
  assign cnt_last = (cnt <= SETTLE_W'(1));
  // A drain already caused by a fallback must not re-trigger on the same lost clock.
  assign fault    = lost_phy && (state != IDLE) && !((state == DRAIN) && fallback);

  // Output flags per state: {main_reset, link_ready, switch_busy}.
  function automatic logic [2:0] flags(input state_t s);
    case (s)
      IDLE:    flags = 3'b100;
      SEL:     flags = 3'b101;
      SETTLE:  flags = 3'b001;
      RUN:     flags = 3'b010;
      DRAIN:   flags = 3'b101;
      default: flags = 3'b100;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state                                  <= IDLE;
      {main_reset, link_ready, switch_busy}  <= flags(IDLE);
      use_phy_clk                            <= 1'b0;
      cnt                                    <= '0;
      switch_err                             <= 1'b0;
      fallback                               <= 1'b0;
    end else begin
      switch_err <= 1'b0;
      if (!enable) begin
        state                                 <= IDLE;
        {main_reset, link_ready, switch_busy} <= flags(IDLE);
        cnt                                   <= '0;
        fallback                              <= 1'b0;
        switch_err                            <= fault;
      end else begin
        case (state)
          IDLE: begin
            state                                 <= SEL;
            {main_reset, link_ready, switch_busy} <= flags(SEL);
            use_phy_clk                           <= tgt;
            cnt                                   <= n_eff;
          end
          RUN: begin
            if (tgt != use_phy_clk) begin
              state                                 <= DRAIN;
              {main_reset, link_ready, switch_busy} <= flags(DRAIN);
              cnt                                   <= n_eff;
              switch_err                            <= lost_phy;
              fallback                              <= lost_phy;
            end
          end
          SEL, SETTLE, DRAIN: begin
            if (fault) begin
              state                                 <= DRAIN;
              {main_reset, link_ready, switch_busy} <= flags(DRAIN);
              cnt                                   <= n_eff;
              switch_err                            <= 1'b1;
              fallback                              <= 1'b1;
            end else if (!cnt_last) begin
              cnt <= cnt - SETTLE_W'(1);
            end else if (state == SEL) begin
              state                                 <= SETTLE;
              {main_reset, link_ready, switch_busy} <= flags(SETTLE);
              cnt                                   <= n_eff;
            end else if (state == SETTLE) begin
              state                                 <= RUN;
              {main_reset, link_ready, switch_busy} <= flags(RUN);
              cnt                                   <= '0;
            end else begin
              state                                 <= SEL;
              {main_reset, link_ready, switch_busy} <= flags(SEL);
              use_phy_clk                           <= tgt;
              cnt                                   <= n_eff;
              fallback                              <= 1'b0;
            end
          end
          default: begin
            state                                 <= IDLE;
            {main_reset, link_ready, switch_busy} <= flags(IDLE);
            cnt                                   <= '0;
          end
        endcase
      end
    end
  end

endmodule
